uart_tx_frame_ctrl: RTL and testbench
=====================================

# uart_tx_frame_ctrl

Frame controller and serializer for the UART transmitter. It accepts a parallel byte with a valid strobe and computes the parity bit. It steps a Moore FSM through the start, data, parity and stop phases, driving `Ser_data`, `PAR_Bit` and `MUX_SEL` into the downstream TX output-select/register stage. It sits directly upstream of that stage, and the frame is fully determined by this block.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `CLK`  in  1: bit-rate clock; one UART bit per cycle.
- `RST`  in  1: asynchronous, active-low reset.
- `P_DATA`  in  DATA_WIDTH: parallel byte to send. Sampled only on acceptance.
- `Data_Valid`  in  1: request strobe. Accepted only in IDLE; ignored otherwise.
- `PAR_EN`  in  1: parity enable. Latched on acceptance.
- `PAR_TYP`  in  1: parity type, 0 = even, 1 = odd. Latched on acceptance.
- `Ser_data`  out  1: current serial data bit; always equals `shift_reg[0]`.
- `PAR_Bit`  out  1: registered parity bit of the latched byte.
- `MUX_SEL`  out  2: output-select code for the downstream stage. 00 = start, 01 = data, 10 = parity, 11 = idle/stop.
- `busy`  out  1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. `MUX_SEL` and `busy` are pure decodes of the state register (Moore):
  - IDLE: `MUX_SEL`=11, `busy`=0.
  - START: `MUX_SEL`=00, `busy`=1.
  - DATA: `MUX_SEL`=01, `busy`=1.
  - PARITY: `MUX_SEL`=10, `busy`=1.
  - STOP: `MUX_SEL`=11, `busy`=1.
- Acceptance occurs in IDLE with `Data_Valid`=1. On that edge the block:
  - loads `shift_reg` ← `P_DATA`;
  - sets `par_en_r` ← `PAR_EN`;
  - sets `PAR_Bit` ← (^`P_DATA`) XOR `PAR_TYP`;
  - clears `bit_cnt` ← 0;
  - transitions to START.
- START → DATA unconditionally.
- DATA:
  - Each cycle, `shift_reg` shifts right with 0 fill and `bit_cnt` increments.
  - Order is LSB first.
  - On the cycle with `bit_cnt`=DATA_WIDTH-1, the next state is PARITY if `par_en_r`=1, else STOP.
- PARITY → STOP unconditionally.
- STOP → IDLE unconditionally. `Data_Valid` in STOP is ignored; there is no back-to-back frame without one IDLE cycle.
- `bit_cnt` width is clog2(DATA_WIDTH). It never wraps within a frame.
- Input changes on `P_DATA`, `PAR_EN` and `PAR_TYP` after acceptance have no effect on the current frame.
- `Data_Valid` held high continuously means one frame is sent, then one IDLE cycle, then the next frame is accepted.
- Illegal or unused state encodings → IDLE on the next edge.

## Timing
- Reset (async assert, sync-to-clock deassert by the system):
  - state = IDLE, `shift_reg` = 0, `bit_cnt` = 0, `par_en_r` = 0;
  - `PAR_Bit` = 0, `Ser_data` = 0, `MUX_SEL` = 11, `busy` = 0.
- Reset asserted mid-frame aborts immediately to the reset values; no partial frame resumes.
- Let E0 be the accepting edge. Counting cycles after E0:
  - cycle 1: START;
  - cycles 2 to DATA_WIDTH+1: DATA bits 0 to DATA_WIDTH-1;
  - then one PARITY cycle if enabled;
  - then one STOP cycle;
  - then IDLE.
- Frame length is DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 with parity (10 or 11 for DATA_WIDTH = 8).
- `busy` rises in the cycle after E0. It falls on the edge that ends STOP. The next acceptance is possible at that same edge plus one cycle, because acceptance requires IDLE.
- The downstream stage registers its selection, so the line reflects `MUX_SEL` and `Ser_data` one cycle later. This block adds no further latency.

## Test plan
- Send 0xA5 with `PAR_EN`=1, `PAR_TYP`=0. Required response:
  - `MUX_SEL` sequence: 00, then 01×8, then 10, then 11;
  - `Ser_data` during DATA: 1,0,1,0,0,1,0,1;
  - `PAR_Bit` = 0;
  - `busy` high for exactly 11 cycles.
- Send 0x00 with `PAR_EN`=0. Required response: no 10 code appears; the frame is 00, 01×8, 11; `busy` is high for 10 cycles.
- Send 0x03 with `PAR_EN`=1, `PAR_TYP`=1. Required response: `PAR_Bit` = 1. Repeat with 0x07: `PAR_Bit` = 0.
- Pulse `Data_Valid` with 0xFF during DATA of a 0x55 frame. Required response: the 0x55 frame completes unchanged, and no second frame starts.
- Assert `RST` low during data bit 3. Required response: `MUX_SEL` = 11 and `busy` = 0 immediately. After release, accepting 0x3C yields a clean full frame.
- Hold `Data_Valid`=1 across two frames, with 0x81 then 0x18 presented. Required response: exactly one IDLE cycle between STOP and the second START, and both frames are bit-correct.

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART transmit frame controller and serializer
//
// Purpose:
//   Accepts a parallel word on a valid strobe while idle, latches the word,
//   the parity enable and the computed parity bit, then walks a Moore FSM
//   through START, DATA (LSB first), optional PARITY and STOP. The downstream
//   output-select stage uses MUX_SEL to pick start/data/parity/stop levels.
//
// Ports:
//   CLK        in   bit-rate clock, one UART bit per cycle
//   RST        in   asynchronous active-low reset
//   P_DATA     in   parallel word, sampled only on acceptance
//   Data_Valid in   request strobe, honoured only in IDLE
//   PAR_EN     in   parity enable, latched on acceptance
//   PAR_TYP    in   parity type (0 even, 1 odd), latched on acceptance
//   Ser_data   out  current serial data bit (shift register LSB)
//   PAR_Bit    out  registered parity bit of the latched word
//   MUX_SEL    out  00 start, 01 data, 10 parity, 11 idle/stop
//   busy       out  high whenever the FSM is not in IDLE

module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  Ser_data,
  output logic                  PAR_Bit,
  output logic [1:0]            MUX_SEL,
  output logic                  busy
);

  // A one-bit counter is still needed when DATA_WIDTH is 1.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    case (state_q)
      S_IDLE: begin
        if (Data_Valid) begin
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
          cnt_d     = '0;
          state_d   = S_START;
        end
      end

      // Shift register already holds bit 0 on its LSB, so no shift here.
      S_START: state_d = S_DATA;

      S_DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == LAST_BIT) begin
          // Counter holds on the last bit so it never wraps inside a frame.
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PARITY: state_d = S_STOP;

      // Data_Valid is deliberately ignored here: one IDLE cycle separates frames.
      S_STOP:   state_d = S_IDLE;

      default:  state_d = S_IDLE;
    endcase
  end

  // Moore decode of the state register only.
  always_comb begin
    MUX_SEL = 2'b11;
    busy    = 1'b0;
    case (state_q)
      S_START:  begin MUX_SEL = 2'b00; busy = 1'b1; end
      S_DATA:   begin MUX_SEL = 2'b01; busy = 1'b1; end
      S_PARITY: begin MUX_SEL = 2'b10; busy = 1'b1; end
      S_STOP:   begin MUX_SEL = 2'b11; busy = 1'b1; end
      default:  begin MUX_SEL = 2'b11; busy = 1'b0; end
    endcase
  end

  assign Ser_data = shift_q[0];
  assign PAR_Bit  = par_bit_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - directed self-checking bench for uart_tx_frame_ctrl

module tb_uart_tx_frame_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       Ser_data;
  logic       PAR_Bit;
  logic [1:0] MUX_SEL;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Ser_data   (Ser_data),
    .PAR_Bit    (PAR_Bit),
    .MUX_SEL    (MUX_SEL),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request and take the accepting edge; optionally scramble the
  // inputs afterwards so the frame only passes if they were latched.
  task automatic accept(input logic [7:0] d, input logic pe, input logic pt, input logic hold);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    tick();
    if (!hold) begin
      Data_Valid = 1'b0;
      P_DATA     = ~d;
      PAR_EN     = ~pe;
      PAR_TYP    = ~pt;
    end
  endtask

  // Entered one step after the accepting edge; leaves one step after the
  // edge that returns to IDLE, having checked that IDLE cycle.
  task automatic check_frame(input logic [7:0] d, input logic pe, input logic exp_par,
                             input int pulse_c, input string tag);
    int len;
    int busy_n;
    logic [1:0] em;
    len    = pe ? 11 : 10;
    busy_n = 0;
    for (int c = 1; c <= len; c++) begin
      if (c == 1)            em = 2'b00;
      else if (c <= 9)       em = 2'b01;
      else if (pe && c == 10) em = 2'b10;
      else                   em = 2'b11;
      check($sformatf("%s_mux_c%0d", tag, c), 32'(MUX_SEL), 32'(em));
      if (c >= 2 && c <= 9)
        check($sformatf("%s_ser_b%0d", tag, c - 2), 32'(Ser_data), 32'(d[c-2]));
      check($sformatf("%s_par_c%0d", tag, c), 32'(PAR_Bit), 32'(exp_par));
      if (busy === 1'b1) busy_n++;
      if (pulse_c != 0) begin
        if (c == pulse_c) begin
          Data_Valid = 1'b1;
          P_DATA     = 8'hFF;
        end else if (c == pulse_c + 1) begin
          Data_Valid = 1'b0;
        end
      end
      tick();
    end
    check($sformatf("%s_idle_mux", tag), 32'(MUX_SEL), 32'd3);
    check($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_busy_len", tag), 32'(busy_n), 32'(len));
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_mux",  32'(MUX_SEL),  32'd3);
    check("rst_busy", 32'(busy),     32'd0);
    check("rst_ser",  32'(Ser_data), 32'd0);
    check("rst_par",  32'(PAR_Bit),  32'd0);
    RST = 1'b1;
    tick();
    check("idle_no_req_busy", 32'(busy), 32'd0);

    // 0xA5, parity even: bits 1,0,1,0,0,1,0,1, parity 0, 11 cycles busy
    accept(8'hA5, 1'b1, 1'b0, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b0, 0, "a5");

    // 0x00, no parity: 10 cycles, no 10 code
    accept(8'h00, 1'b0, 1'b0, 1'b0);
    check_frame(8'h00, 1'b0, 1'b0, 0, "00");

    // Odd parity: 0x03 -> 1, 0x07 -> 0
    accept(8'h03, 1'b1, 1'b1, 1'b0);
    check_frame(8'h03, 1'b1, 1'b1, 0, "03");
    accept(8'h07, 1'b1, 1'b1, 1'b0);
    check_frame(8'h07, 1'b1, 1'b0, 0, "07");

    // 0x55 odd parity (-> 1), Data_Valid pulsed with 0xFF during DATA
    accept(8'h55, 1'b1, 1'b1, 1'b0);
    check_frame(8'h55, 1'b1, 1'b1, 4, "55");
    tick();
    check("55_no_second_busy", 32'(busy), 32'd0);
    check("55_no_second_mux",  32'(MUX_SEL), 32'd3);

    // Reset during data bit 3 of 0x96 (bit 3 = 0)
    accept(8'h96, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check("rst_mid_mux_before", 32'(MUX_SEL), 32'd1);
    check("rst_mid_ser_before", 32'(Ser_data), 32'd0);
    RST = 1'b0;
    #1;
    check("rst_mid_mux",  32'(MUX_SEL),  32'd3);
    check("rst_mid_busy", 32'(busy),     32'd0);
    check("rst_mid_ser",  32'(Ser_data), 32'd0);
    check("rst_mid_par",  32'(PAR_Bit),  32'd0);
    #2;
    RST = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    accept(8'h3C, 1'b1, 1'b0, 1'b0);
    check_frame(8'h3C, 1'b1, 1'b0, 0, "3c");

    // Data_Valid held: 0x81 (parity even -> 0) then 0x18 (no parity)
    accept(8'h81, 1'b1, 1'b0, 1'b1);
    P_DATA = 8'h18;
    PAR_EN = 1'b0;
    check_frame(8'h81, 1'b1, 1'b0, 0, "81");
    tick();
    check_frame(8'h18, 1'b0, 1'b0, 0, "18");
    Data_Valid = 1'b0;
    tick();
    check("end_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
